mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: instruction-sequencing FSM, condition check,
// ALU command decode and the architectural {N,Z,C,V} flag register.
module mc_controller (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] FlagReg,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] cmd;
    logic       is_cmp;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;
    logic       pc_we, ir_we, reg_we, mem_we;

    assign cmd    = Funct[4:1];
    assign is_cmp = (cmd == 4'b1010);
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f & !z_f;
            4'b1001: cond_ex = !c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flags are captured at the close of an execute state for S-suffixed ops and CMP.
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && (Funct[0] || is_cmp))
            flags_d = ALUFlags;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_ex || Op == 2'b11) state_d = S_FETCH;
                else if (Op == 2'b01)        state_d = S_MEMADR;
                else if (Op == 2'b10)        state_d = S_BRANCH;
                else if (Funct[5])           state_d = S_EXECI;
                else                         state_d = S_EXECR;
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = 1'b1;
                pc_we     = (Rd == 4'hF);
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_we = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                case (cmd)
                    4'b0100: ALUControl = 3'b000;
                    4'b0010: ALUControl = 3'b001;
                    4'b1010: ALUControl = 3'b001;
                    4'b0000: ALUControl = 3'b010;
                    4'b1100: ALUControl = 3'b011;
                    default: ALUControl = 3'b000;
                endcase
            end
            S_ALUWB: begin
                reg_we = !is_cmp;
                pc_we  = !is_cmp && (Rd == 4'hF);
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate/register-source selects follow the instruction class, not the state.
    always_comb begin
        case (Op)
            2'b01:   ImmSrc = 2'b01;
            2'b10:   ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
        RegSrc = {(Op == 2'b01) && !Funct[0], (Op == 2'b10)};
    end

    assign PCWrite  = pc_we  & Reset;
    assign IRWrite  = ir_we  & Reset;
    assign RegWrite = reg_we & Reset;
    assign MemWrite = mem_we & Reset;
    assign FlagReg  = flags_q;
    assign State    = state_q;

endmodule
